// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin inst/data to single SRAM-like slave arbiter with watchdog
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic M_INST = 1'b0;
  localparam logic M_DATA = 1'b1;

  state_t      r_state;
  logic        r_last_grant;
  logic        r_owner;
  logic        r_cmd_wr;
  logic [3:0]  r_cmd_wstrb;
  logic [31:0] r_cmd_addr;
  logic [31:0] r_cmd_wdata;
  logic [31:0] r_cnt;
  logic        r_timeout_err;

  logic        w_idle;
  logic        w_busy;
  logic        w_any_req;
  logic        w_pick_data;
  logic        w_timeout;
  logic        w_done_real;
  logic        w_done_to;
  logic        w_done;
  logic [31:0] w_rdata;

  // Grant choice and completion detection; everything is gated by rst so
  // no handshake escapes while reset is held.
  always_comb begin
    w_idle      = rst && (r_state == S_IDLE);
    w_busy      = rst && ((r_state == S_REQ) || (r_state == S_WAIT));
    w_any_req   = inst_req || data_req;
    // data wins when alone, or on a tie when inst held the previous grant
    w_pick_data = data_req && (!inst_req || (r_last_grant == M_INST));
    w_timeout   = (TIMEOUT_CYC != 0) && (r_cnt == (TIMEOUT_CYC - 1));
    // a real completion beats a simultaneous watchdog expiry
    w_done_real = rst && (r_state == S_WAIT) && mem_data_ok;
    w_done_to   = w_busy && w_timeout && !w_done_real;
    w_done      = w_done_real || w_done_to;
  end

  // Master-side handshakes: accept pulse in IDLE, completion routed to the owner
  always_comb begin
    inst_addr_ok = w_idle && w_any_req && !w_pick_data;
    data_addr_ok = w_idle && w_pick_data;
    inst_data_ok = w_done && (r_owner == M_INST);
    data_data_ok = w_done && (r_owner == M_DATA);
    w_rdata      = w_done_real ? mem_rdata : ERR_RDATA;
    inst_rdata   = inst_data_ok ? w_rdata : 32'h0;
    data_rdata   = data_data_ok ? w_rdata : 32'h0;
  end

  assign mem_req     = rst && (r_state == S_REQ);
  assign mem_wr      = r_cmd_wr;
  assign mem_wstrb   = r_cmd_wstrb;
  assign mem_addr    = r_cmd_addr;
  assign mem_wdata   = r_cmd_wdata;
  assign timeout_err = r_timeout_err;

  // Transaction FSM: latch the winner, present it to the slave, wait for completion or watchdog
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_last_grant  <= M_INST;
      r_owner       <= M_INST;
      r_cmd_wr      <= 1'b0;
      r_cmd_wstrb   <= 4'h0;
      r_cmd_addr    <= 32'h0;
      r_cmd_wdata   <= 32'h0;
      r_cnt         <= 32'h0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner      <= w_pick_data;
            r_last_grant <= w_pick_data;
            r_cmd_wr     <= w_pick_data ? data_wr    : inst_wr;
            r_cmd_wstrb  <= w_pick_data ? data_wstrb : inst_wstrb;
            r_cmd_addr   <= w_pick_data ? data_addr  : inst_addr;
            r_cmd_wdata  <= w_pick_data ? data_wdata : inst_wdata;
            r_cnt        <= 32'h0;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 32'd1;
          if (w_timeout && (TIMEOUT_CYC != 0)) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else if (mem_addr_ok) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 32'd1;
          if (mem_data_ok) begin
            r_state <= S_IDLE;
          end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  localparam int unsigned TO_CYC = 8;
  localparam logic [31:0] ERR_RD = 32'hDEAD_BEEF;
  localparam int MI = 0;
  localparam int MD = 1;

  typedef struct packed {
    logic        wr;
    logic [3:0]  ws;
    logic [31:0] a;
    logic [31:0] wd;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  m_req = 2'b00;
  logic [1:0]  m_wr  = 2'b00;
  logic [3:0]  m_ws    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];

  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, timeout_err;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata   = 32'h0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cyc [2];
  int req_len = 0;
  int last_req_len = 0;
  logic prev_req = 1'b0;

  cmd_t        cmd_q [$];
  logic [31:0] exp_i [$];
  logic [31:0] exp_d [$];
  int          grant_log [$];

  int   s_addr_dly = 0;
  int   s_data_dly = 0;
  bit   s_mute = 1'b0;
  int   s_phase = 0;
  int   s_cnt = 0;
  logic [31:0] s_addr = 32'h0;

  mem_bus_arbiter #(.TIMEOUT_CYC(TO_CYC), .ERR_RDATA(ERR_RD)) dut (
    .clk(clk), .rst(rst),
    .inst_req(m_req[0]), .inst_wr(m_wr[0]), .inst_wstrb(m_ws[0]),
    .inst_addr(m_addr[0]), .inst_wdata(m_wdata[0]),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(m_req[1]), .data_wr(m_wr[1]), .data_wstrb(m_ws[1]),
    .data_addr(m_addr[1]), .data_wdata(m_wdata[1]),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h1000) ? 32'h1234_5678 : (a ^ 32'hA5A5_5A5A);
  endfunction

  // slave model: accepts after s_addr_dly REQ cycles, answers s_data_dly cycles later
  always @(negedge clk) begin
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
    if (s_phase == 0) begin
      if (mem_req && !s_mute) begin
        if (s_cnt == s_addr_dly) begin
          mem_addr_ok = 1'b1;
          s_addr = mem_addr;
          s_phase = 1;
          s_cnt = 0;
        end else begin
          s_cnt++;
        end
      end else begin
        s_cnt = 0;
      end
    end else begin
      if (s_cnt == s_data_dly) begin
        mem_data_ok = 1'b1;
        mem_rdata = rd_fn(s_addr);
        s_phase = 0;
        s_cnt = 0;
      end else begin
        s_cnt++;
      end
    end
  end

  // monitor: completions against per-master queues, slave command against accepted command
  always @(negedge clk) begin
    #2;
    check("dual_data_ok", {31'b0, inst_data_ok & data_data_ok}, 32'h0);
    if (inst_data_ok) begin
      done_cyc[0] = cyc;
      if (exp_i.size() == 0) check("inst_spurious_data_ok", 32'd1, 32'd0);
      else check("inst_rdata", inst_rdata, exp_i.pop_front());
    end else begin
      check("inst_rdata_idle", inst_rdata, 32'h0);
    end
    if (data_data_ok) begin
      done_cyc[1] = cyc;
      if (exp_d.size() == 0) check("data_spurious_data_ok", 32'd1, 32'd0);
      else check("data_rdata", data_rdata, exp_d.pop_front());
    end else begin
      check("data_rdata_idle", data_rdata, 32'h0);
    end
    if (mem_req) begin
      req_len++;
      if (cmd_q.size() == 0) begin
        check("mem_req_unexpected", 32'd1, 32'd0);
      end else begin
        check("mem_addr", mem_addr, cmd_q[0].a);
        check("mem_wdata", mem_wdata, cmd_q[0].wd);
        check("mem_wr_wstrb", {27'b0, mem_wr, mem_wstrb}, {27'b0, cmd_q[0].wr, cmd_q[0].ws});
      end
    end else if (prev_req) begin
      last_req_len = req_len;
      req_len = 0;
      if (cmd_q.size() > 0) void'(cmd_q.pop_front());
    end
    prev_req = mem_req;
  end

  // raise a request at the current negedge, hold it until accepted, drop it one negedge later
  task automatic issue(input int m, input logic wr, input logic [3:0] ws, input logic [31:0] a,
                       input logic [31:0] wd, input bit exp_done, input logic [31:0] exp_rd,
                       output int acc_cyc, output int waited);
    cmd_t c;
    bit   accepted;
    accepted = 1'b0;
    acc_cyc = -1;
    waited = 0;
    m_req[m] = 1'b1;
    m_wr[m] = wr;
    m_ws[m] = ws;
    m_addr[m] = a;
    m_wdata[m] = wd;
    if (exp_done) begin
      if (m == MI) exp_i.push_back(exp_rd);
      else exp_d.push_back(exp_rd);
    end
    forever begin
      #2;
      if ((m == MI) ? inst_addr_ok : data_addr_ok) begin
        accepted = 1'b1;
        break;
      end
      if (waited == 100) break;
      waited++;
      @(negedge clk);
    end
    if (!accepted) begin
      check("addr_ok_wait", 32'd0, 32'd1);
    end else begin
      c.wr = wr;
      c.ws = ws;
      c.a = a;
      c.wd = wd;
      cmd_q.push_back(c);
      grant_log.push_back(m);
      acc_cyc = cyc;
    end
    @(negedge clk);
    m_req[m] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_i.size() != 0 || exp_d.size() != 0 || cmd_q.size() != 0 || mem_req) && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n == 200) check("idle_wait", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int acc_a, w_a, acc_b, w_b;
    for (int i = 0; i < 2; i++) begin
      m_ws[i] = 4'h0;
      m_addr[i] = 32'h0;
      m_wdata[i] = 32'h0;
      done_cyc[i] = 0;
    end

    // reset held with both masters requesting, then the first grant goes to data
    fork
      issue(MD, 1'b0, 4'hF, 32'h2000, 32'h0, 1'b1, rd_fn(32'h2000), acc_a, w_a);
      issue(MI, 1'b0, 4'hF, 32'h3000, 32'h0, 1'b1, rd_fn(32'h3000), acc_b, w_b);
      begin
        repeat (3) @(negedge clk);
        #2;
        check("rst_addr_ok", {30'b0, inst_addr_ok, data_addr_ok}, 32'h0);
        check("rst_data_ok", {30'b0, inst_data_ok, data_data_ok}, 32'h0);
        check("rst_mem_ctl", {26'b0, mem_req, mem_wr, mem_wstrb}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_timeout_err", {31'b0, timeout_err}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("first_grant_data", {31'b0, data_addr_ok}, 32'h1);
        check("first_grant_inst", {31'b0, inst_addr_ok}, 32'h0);
      end
    join
    wait_idle();

    // contention: both masters request back to back
    grant_log.delete();
    fork
      begin
        for (int k = 0; k < 3; k++)
          issue(MD, 1'b0, 4'hF, 32'h0000_D000 + k * 16, 32'h0, 1'b1, rd_fn(32'h0000_D000 + k * 16), acc_a, w_a);
      end
      begin
        for (int k = 0; k < 3; k++)
          issue(MI, 1'b0, 4'hF, 32'h0000_A000 + k * 16, 32'h0, 1'b1, rd_fn(32'h0000_A000 + k * 16), acc_b, w_b);
      end
    join
    wait_idle();
    check("grant_count", grant_log.size(), 32'd6);
    for (int k = 0; k < grant_log.size(); k++)
      check("grant_order", grant_log[k], (k % 2 == 0) ? MD : MI);

    // single read with best-case slave
    issue(MD, 1'b0, 4'hF, 32'h1000, 32'h0, 1'b1, 32'h1234_5678, acc_a, w_a);
    #2;
    check("single_mem_req", {31'b0, mem_req}, 32'h1);
    wait_idle();
    check("single_accept_wait", w_a, 32'd0);
    check("single_latency", done_cyc[1] - acc_a, 32'd2);

    // write with slave accepting late
    s_addr_dly = 5;
    issue(MD, 1'b1, 4'b0011, 32'h4000, 32'hAABB_CCDD, 1'b1, rd_fn(32'h4000), acc_a, w_a);
    wait_idle();
    s_addr_dly = 0;
    check("write_req_len", last_req_len, 32'd6);
    check("write_latency", done_cyc[1] - acc_a, 32'd7);

    // watchdog: silent slave
    s_mute = 1'b1;
    issue(MI, 1'b0, 4'hF, 32'h5000, 32'h0, 1'b1, ERR_RD, acc_a, w_a);
    wait_idle();
    s_mute = 1'b0;
    check("timeout_latency", done_cyc[0] - acc_a, TO_CYC);
    check("timeout_err_set", {31'b0, timeout_err}, 32'h1);
    issue(MI, 1'b0, 4'hF, 32'h6000, 32'h0, 1'b1, rd_fn(32'h6000), acc_a, w_a);
    wait_idle();
    check("post_timeout_latency", done_cyc[0] - acc_a, 32'd2);
    check("timeout_err_sticky", {31'b0, timeout_err}, 32'h1);

    // reset pulse while waiting for data; the late data_ok must be dropped
    s_data_dly = 4;
    issue(MD, 1'b0, 4'hF, 32'h7000, 32'h0, 1'b0, 32'h0, acc_a, w_a);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    check("rmw_mem_req_idle", {31'b0, mem_req}, 32'h0);
    check("rmw_timeout_err_cleared", {31'b0, timeout_err}, 32'h0);
    @(negedge clk);
    s_data_dly = 0;
    issue(MI, 1'b0, 4'hF, 32'h8000, 32'h0, 1'b1, rd_fn(32'h8000), acc_a, w_a);
    wait_idle();
    check("rmw_accept_wait", w_a, 32'd0);
    check("rmw_next_latency", done_cyc[0] - acc_a, 32'd2);

    check("queues_empty", exp_i.size() + exp_d.size() + cmd_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
